issue_select_sched: RTL and testbench
=====================================

Name: issue_select_sched

Overview:
- Issue-stage select scheduler for one functional unit (FU) port.
- Each cycle it takes the ready vector from the issue queue and picks one entry round-robin.
- It presents the pick as a registered grant with a valid/ready handshake to the FU.
- It stalls further grants while a non-pipelined long-latency op occupies the FU.

Parameters:
ENTRIES, 32, issue queue entries (power of 2, >=2)
ENTRIES_LOG, 5, log2(ENTRIES)
BUSY_CYCLES, 4, FU occupancy in cycles after issuing a long op (>=1)

Ports:
clk_i  input  1  clock
rst_i  input  1  synchronous active-high reset
req_vec_i  input  ENTRIES  ready-to-issue entries
long_vec_i  input  ENTRIES  per-entry long-latency (non-pipelined) flag
flush_i  input  1  pipeline flush
fu_ready_i  input  1  FU accepts grant this cycle
grant_valid_o  output  1  grant offered
grant_idx_o  output  ENTRIES_LOG  granted entry index
grant_onehot_o  output  ENTRIES  one-hot of grant_idx_o, zero when !grant_valid_o
issued_o  output  1  grant_valid_o & fu_ready_i (combinational)
busy_o  output  1  FSM in BLOCK

Behaviour:
- Interface: one clock clk_i; reset rst_i is synchronous, active-high.
- Reset values:
  - FSM=IDLE; grant_valid_o=0, grant_idx_o=0, grant_onehot_o=0, busy_o=0.
  - ptr=ENTRIES-1, so entry 0 has first priority.
  - cnt=0; captured long flag=0.
- Select function sel(v):
  - m = v & bits strictly above ptr.
  - If m!=0, pick the lowest set bit of m; else pick the lowest set bit of v.
  - ptr=ENTRIES-1 gives m=0, i.e. wrap to a plain lowest-index pick.
- States:
  - IDLE: if req_vec_i!=0, register sel(req_vec_i) and its long bit, then go OFFER. Else stay.
  - OFFER: grant_valid_o=1.
    - Without handshake: grant_idx_o and grant_onehot_o hold stable. The queue keeps that req bit set.
    - On handshake: ptr<=grant_idx_o.
      - If the captured long flag is set: cnt<=BUSY_CYCLES, go BLOCK.
      - Else, if (req_vec_i & ~grant_onehot_o)!=0: register sel of that vector, stay OFFER (back-to-back, 1 issue/cycle).
      - Else go IDLE.
  - BLOCK: grant_valid_o=0.
    - cnt>1: decrement.
    - cnt==1: if req_vec_i!=0, register sel(req_vec_i) and go OFFER; else go IDLE.
- Latency:
  - Request in IDLE at cycle t -> grant_valid_o at t+1.
  - Long op issued at t -> grant_valid_o low t+1..t+BUSY_CYCLES; earliest next grant at t+BUSY_CYCLES+1.
- Flush:
  - Highest priority: next state IDLE, grant_valid_o<=0, cnt<=0. ptr updates only if a handshake coincides.
  - Flush with handshake in the same cycle: issued_o=1 (the op is issued), ptr updates, no BLOCK entry.
- Reset mid-BLOCK or mid-OFFER: all state returns to reset values next cycle.
- long_vec_i is sampled only at selection time.

Optional Feature:
- Macro: ISSUE_SELECT_PERF_EN.
- When defined, three 32-bit saturating counters are added. They clear only on reset.
  - perf_issue_o: counts issued_o.
  - perf_stall_o: counts cycles with grant_valid_o & !fu_ready_i.
  - perf_block_o: counts cycles in BLOCK.
- When undefined, these ports and counters are absent and behaviour is otherwise identical.

Decomposition:
- Package issue_pkg:
  - FSM state enum (IDLE, OFFER, BLOCK).
  - Default ENTRIES/ENTRIES_LOG constants.
  - Perf counter width constant (32).
- Sub-module issue_pick_first: combinational lowest-set-bit finder (vector -> index + found flag). It is instantiated twice: masked and unmasked vectors.

Test Plan:
- Reset, then req_vec_i=0x0000_0005, fu_ready_i=1: grant idx 0 at t+1, idx 2 at t+2, then IDLE.
- Round-robin check:
  - Setup: req_vec_i=0x8000_0001 held, fu_ready_i=1.
  - Expect: grants alternate 0,31,0,31 every cycle.
  - Expect: ptr wrap from 31 falls back to idx 0.
- Stall hold: grant idx 3 offered, fu_ready_i=0 for 5 cycles -> idx/onehot stable, perf_stall_o=5 (PERF_EN), no issued_o.
- Long op, BUSY_CYCLES=4:
  - Stimulus: issue entry 1 with long bit at t, req bit 6 pending.
  - Expect: grant_valid_o=0 and busy_o=1 for t+1..t+4.
  - Expect: idx 6 at t+5.
- Flush during BLOCK (cnt=3): next cycle IDLE, busy_o=0, new grant on the following cycle if req pending.
- Flush coincident with handshake of long entry: issued_o=1, next state IDLE (no BLOCK), ptr=granted idx.

Source files
------------

// File: rtl/issue_pkg.sv
// issue_pkg: shared types and constants for the issue select scheduler.
// Holds the FSM state enum, default sizes and the perf counter width.
package issue_pkg;

  localparam int ENTRIES_DEF     = 32;
  localparam int ENTRIES_LOG_DEF = 5;
  localparam int PERF_W          = 32;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    OFFER = 2'd1,
    BLOCK = 2'd2
  } state_e;

endpackage

// File: rtl/issue_pick_first.sv
// issue_pick_first: lowest-set-bit finder (combinational).
// Ports: vec_i in, idx_o = lowest set index, found_o = vec_i != 0.
module issue_pick_first
  import issue_pkg::*;
#(
  parameter int W  = ENTRIES_DEF,
  parameter int LW = ENTRIES_LOG_DEF
) (
  input  logic [W-1:0]  vec_i,
  output logic [LW-1:0] idx_o,
  output logic          found_o
);

  always_comb begin
    idx_o   = '0;
    found_o = 1'b0;
    for (int i = W - 1; i >= 0; i--) begin
      if (vec_i[i]) begin
        idx_o   = LW'(i);
        found_o = 1'b1;
      end
    end
  end

endmodule

// File: rtl/issue_select_sched.sv
// issue_select_sched: round-robin issue select for one FU port.
// Ports: clk_i, rst_i (sync, high), req_vec_i, long_vec_i, flush_i,
//   fu_ready_i in; grant_valid_o, grant_idx_o, grant_onehot_o,
//   issued_o, busy_o out. With ISSUE_SELECT_PERF_EN defined adds
//   perf_issue_o, perf_stall_o, perf_block_o saturating counters.
module issue_select_sched
  import issue_pkg::*;
#(
  parameter int ENTRIES     = ENTRIES_DEF,
  parameter int ENTRIES_LOG = ENTRIES_LOG_DEF,
  parameter int BUSY_CYCLES = 4
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  input  logic [ENTRIES-1:0]     req_vec_i,
  input  logic [ENTRIES-1:0]     long_vec_i,
  input  logic                   flush_i,
  input  logic                   fu_ready_i,
  output logic                   grant_valid_o,
  output logic [ENTRIES_LOG-1:0] grant_idx_o,
  output logic [ENTRIES-1:0]     grant_onehot_o,
  output logic                   issued_o,
  output logic                   busy_o
`ifdef ISSUE_SELECT_PERF_EN
  ,
  output logic [PERF_W-1:0]      perf_issue_o,
  output logic [PERF_W-1:0]      perf_stall_o,
  output logic [PERF_W-1:0]      perf_block_o
`endif
);

  localparam int CW = $clog2(BUSY_CYCLES + 1);
  localparam logic [CW-1:0] BUSY_INIT = CW'(BUSY_CYCLES);

  state_e                 state_q, state_d;
  logic [ENTRIES_LOG-1:0] idx_q, idx_d;
  logic [ENTRIES_LOG-1:0] ptr_q, ptr_d;
  logic [CW-1:0]          cnt_q, cnt_d;
  logic                   long_q, long_d;

  logic [ENTRIES_LOG-1:0] ptr_eff;
  logic [ENTRIES-1:0]     sel_vec;
  logic [ENTRIES-1:0]     above;
  logic [ENTRIES-1:0]     m_vec;
  logic [ENTRIES_LOG-1:0] idx_m, idx_v, sel_idx;
  logic                   found_m, found_v;

  assign grant_valid_o = (state_q == OFFER);
  assign busy_o        = (state_q == BLOCK);
  assign grant_idx_o   = idx_q;
  assign issued_o      = grant_valid_o & fu_ready_i;

  always_comb begin
    grant_onehot_o = '0;
    if (grant_valid_o) grant_onehot_o[idx_q] = 1'b1;
  end

  // Back-to-back picks rotate from the entry being issued now,
  // and exclude it since the queue drops it only next cycle.
  always_comb begin
    ptr_eff = (state_q == OFFER) ? idx_q : ptr_q;
    sel_vec = (state_q == OFFER) ? (req_vec_i & ~grant_onehot_o)
                                 : req_vec_i;
    for (int i = 0; i < ENTRIES; i++) begin
      above[i] = (i > int'(ptr_eff));
    end
    m_vec = sel_vec & above;
  end

  issue_pick_first #(
    .W  (ENTRIES),
    .LW (ENTRIES_LOG)
  ) u_pick_m (
    .vec_i   (m_vec),
    .idx_o   (idx_m),
    .found_o (found_m)
  );

  issue_pick_first #(
    .W  (ENTRIES),
    .LW (ENTRIES_LOG)
  ) u_pick_v (
    .vec_i   (sel_vec),
    .idx_o   (idx_v),
    .found_o (found_v)
  );

  assign sel_idx = found_m ? idx_m : idx_v;

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    ptr_d   = ptr_q;
    cnt_d   = cnt_q;
    long_d  = long_q;
    if (issued_o) ptr_d = idx_q;
    if (flush_i) begin
      state_d = IDLE;
      cnt_d   = '0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (found_v) begin
            idx_d   = sel_idx;
            long_d  = long_vec_i[sel_idx];
            state_d = OFFER;
          end
        end
        OFFER: begin
          if (issued_o) begin
            if (long_q) begin
              cnt_d   = BUSY_INIT;
              state_d = BLOCK;
            end else if (found_v) begin
              idx_d  = sel_idx;
              long_d = long_vec_i[sel_idx];
            end else begin
              state_d = IDLE;
            end
          end
        end
        BLOCK: begin
          if (cnt_q > CW'(1)) begin
            cnt_d = cnt_q - CW'(1);
          end else begin
            cnt_d = '0;
            if (found_v) begin
              idx_d   = sel_idx;
              long_d  = long_vec_i[sel_idx];
              state_d = OFFER;
            end else begin
              state_d = IDLE;
            end
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= IDLE;
      idx_q   <= '0;
      ptr_q   <= ENTRIES_LOG'(ENTRIES - 1);
      cnt_q   <= '0;
      long_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      ptr_q   <= ptr_d;
      cnt_q   <= cnt_d;
      long_q  <= long_d;
    end
  end

`ifdef ISSUE_SELECT_PERF_EN
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      perf_issue_o <= '0;
      perf_stall_o <= '0;
      perf_block_o <= '0;
    end else begin
      if (issued_o && perf_issue_o != '1)
        perf_issue_o <= perf_issue_o + PERF_W'(1);
      if (grant_valid_o && !fu_ready_i && perf_stall_o != '1)
        perf_stall_o <= perf_stall_o + PERF_W'(1);
      if (busy_o && perf_block_o != '1)
        perf_block_o <= perf_block_o + PERF_W'(1);
    end
  end
`endif

endmodule

// File: tb/tb_issue_select_sched.sv
// tb_issue_select_sched: vector table + scoreboard bench
// for issue_select_sched (ENTRIES=32, BUSY_CYCLES=4).
module tb_issue_select_sched;

  logic        clk = 1'b0;
  logic        rst_i;
  logic [31:0] req_vec_i;
  logic [31:0] long_vec_i;
  logic        flush_i;
  logic        fu_ready_i;
  logic        grant_valid_o;
  logic [4:0]  grant_idx_o;
  logic [31:0] grant_onehot_o;
  logic        issued_o;
  logic        busy_o;
`ifdef ISSUE_SELECT_PERF_EN
  logic [31:0] perf_issue_o;
  logic [31:0] perf_stall_o;
  logic [31:0] perf_block_o;
`endif

  always #5 clk = ~clk;

  issue_select_sched #(
    .ENTRIES     (32),
    .ENTRIES_LOG (5),
    .BUSY_CYCLES (4)
  ) dut (
    .clk_i          (clk),
    .rst_i          (rst_i),
    .req_vec_i      (req_vec_i),
    .long_vec_i     (long_vec_i),
    .flush_i        (flush_i),
    .fu_ready_i     (fu_ready_i),
    .grant_valid_o  (grant_valid_o),
    .grant_idx_o    (grant_idx_o),
    .grant_onehot_o (grant_onehot_o),
    .issued_o       (issued_o),
    .busy_o         (busy_o)
`ifdef ISSUE_SELECT_PERF_EN
    ,
    .perf_issue_o   (perf_issue_o),
    .perf_stall_o   (perf_stall_o),
    .perf_block_o   (perf_block_o)
`endif
  );

  typedef struct {
    int          id;
    bit          rst;
    logic [31:0] req;
    logic [31:0] lng;
    bit          fl;
    bit          rdy;
    bit          v;
    int          idx;
    bit          busy;
    bit          iss;
  } vec_t;

  vec_t tbl[$];
  vec_t sb[$];
  vec_t e;
  int   compared = 0;
  int   mism     = 0;

  task automatic add(bit rst, logic [31:0] req, logic [31:0] lng,
                     bit fl, bit rdy, bit v, int idx, bit busy,
                     bit iss);
    vec_t r;
    r.id   = tbl.size();
    r.rst  = rst;
    r.req  = req;
    r.lng  = lng;
    r.fl   = fl;
    r.rdy  = rdy;
    r.v    = v;
    r.idx  = idx;
    r.busy = busy;
    r.iss  = iss;
    tbl.push_back(r);
  endtask

  task automatic chk(string nm, int id, logic [31:0] act,
                     logic [31:0] exp);
    compared++;
    if (act !== exp) begin
      mism++;
      $display("FAIL %s row %0d: got %h want %h", nm, id, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (sb.size() != 0) begin
      logic [31:0] eoh;
      e   = sb.pop_front();
      eoh = e.v ? (32'h1 << e.idx) : 32'h0;
      chk("valid", e.id, {31'b0, grant_valid_o}, {31'b0, e.v});
      chk("onehot", e.id, grant_onehot_o, eoh);
      chk("busy", e.id, {31'b0, busy_o}, {31'b0, e.busy});
      chk("issued", e.id, {31'b0, issued_o}, {31'b0, e.iss});
      if (e.idx >= 0)
        chk("idx", e.id, {27'b0, grant_idx_o}, 32'(e.idx));
`ifdef ISSUE_SELECT_PERF_EN
      case (e.id)
        18: begin
          chk("perf_issue", e.id, perf_issue_o, 32'd7);
          chk("perf_stall", e.id, perf_stall_o, 32'd5);
        end
        26: begin
          chk("perf_issue", e.id, perf_issue_o, 32'd9);
          chk("perf_block", e.id, perf_block_o, 32'd4);
        end
        33: begin
          chk("perf_issue", e.id, perf_issue_o, 32'd11);
          chk("perf_stall", e.id, perf_stall_o, 32'd5);
          chk("perf_block", e.id, perf_block_o, 32'd6);
        end
        default: ;
      endcase
`endif
    end
  end

  initial begin
    rst_i      = 1'b1;
    req_vec_i  = '0;
    long_vec_i = '0;
    flush_i    = 1'b0;
    fu_ready_i = 1'b0;

    // rst req lng fl rdy | v idx busy iss
    add(1, 0, 0, 0, 0, 0, 0, 0, 0);
    add(0, 5, 0, 0, 1, 0, -1, 0, 0);
    add(0, 5, 0, 0, 1, 1, 0, 0, 1);
    add(0, 4, 0, 0, 1, 1, 2, 0, 1);
    add(0, 0, 0, 0, 1, 0, -1, 0, 0);
    add(0, 32'h8000_0001, 0, 0, 1, 0, -1, 0, 0);
    add(0, 32'h8000_0001, 0, 0, 1, 1, 31, 0, 1);
    add(0, 32'h8000_0001, 0, 0, 1, 1, 0, 0, 1);
    add(0, 32'h8000_0001, 0, 0, 1, 1, 31, 0, 1);
    add(0, 1, 0, 0, 1, 1, 0, 0, 1);
    add(0, 0, 0, 0, 1, 0, -1, 0, 0);
    add(0, 8, 0, 0, 0, 0, -1, 0, 0);
    for (int i = 0; i < 5; i++)
      add(0, 8, 0, 0, 0, 1, 3, 0, 0);
    add(0, 8, 0, 0, 1, 1, 3, 0, 1);
    add(0, 0, 0, 0, 1, 0, -1, 0, 0);
    add(0, 2, 2, 0, 1, 0, -1, 0, 0);
    add(0, 32'h42, 2, 0, 1, 1, 1, 0, 1);
    for (int i = 0; i < 4; i++)
      add(0, 32'h40, 2, 0, 1, 0, -1, 1, 0);
    add(0, 32'h40, 2, 0, 1, 1, 6, 0, 1);
    add(0, 0, 0, 0, 1, 0, -1, 0, 0);
    add(0, 32'h80, 32'h80, 0, 1, 0, -1, 0, 0);
    add(0, 32'h80, 32'h80, 0, 1, 1, 7, 0, 1);
    add(0, 1, 0, 0, 1, 0, -1, 1, 0);
    add(0, 1, 0, 1, 1, 0, -1, 1, 0);
    add(0, 1, 0, 0, 1, 0, -1, 0, 0);
    add(0, 0, 0, 0, 1, 1, 0, 0, 1);
    add(0, 0, 0, 0, 1, 0, -1, 0, 0);
    add(0, 32'h10, 32'h10, 0, 1, 0, -1, 0, 0);
    add(0, 32'h10, 32'h10, 1, 1, 1, 4, 0, 1);
    add(0, 32'h24, 0, 0, 0, 0, -1, 0, 0);
    add(0, 32'h24, 0, 0, 0, 1, 5, 0, 0);
    add(0, 32'h24, 0, 1, 0, 1, 5, 0, 0);
    add(0, 0, 0, 0, 0, 0, -1, 0, 0);
    add(0, 32'h24, 0, 0, 1, 0, -1, 0, 0);
    add(0, 32'h24, 0, 0, 1, 1, 5, 0, 1);
    add(0, 4, 0, 0, 1, 1, 2, 0, 1);
    add(0, 0, 0, 0, 0, 0, -1, 0, 0);
    add(0, 8, 0, 0, 0, 0, -1, 0, 0);
    add(1, 8, 0, 0, 0, 1, 3, 0, 0);
    add(0, 0, 0, 0, 0, 0, 0, 0, 0);
    add(0, 32'h24, 0, 0, 1, 0, -1, 0, 0);
    add(0, 4, 0, 0, 1, 1, 2, 0, 1);
    add(0, 0, 0, 0, 1, 0, -1, 0, 0);
    add(0, 2, 2, 0, 1, 0, -1, 0, 0);
    add(0, 0, 2, 0, 1, 1, 1, 0, 1);
    add(1, 0, 0, 0, 1, 0, -1, 1, 0);
    add(0, 0, 0, 0, 1, 0, 0, 0, 0);
    // full-vector sweep: one issue per cycle, 0..31 in order
    add(0, 32'hffff_ffff, 0, 0, 1, 0, -1, 0, 0);
    for (int k = 0; k < 32; k++)
      add(0, 32'hffff_ffff << k, 0, 0, 1, 1, k, 0, 1);
    add(0, 0, 0, 0, 1, 0, -1, 0, 0);

    @(posedge clk);
    #1;
    foreach (tbl[i]) begin
      rst_i      = tbl[i].rst;
      req_vec_i  = tbl[i].req;
      long_vec_i = tbl[i].lng;
      flush_i    = tbl[i].fl;
      fu_ready_i = tbl[i].rdy;
      sb.push_back(tbl[i]);
      @(posedge clk);
      #1;
    end
    for (int i = 0; i < 4 && sb.size() != 0; i++) @(negedge clk);
    compared++;
    if (sb.size() != 0) begin
      mism++;
      $display("FAIL drain: got %0d left want 0", sb.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             compared, mism);
    $finish;
  end

endmodule
